// File: rtl/hellow_world_cpu_cpu_oci_pkg.sv
// Shared types for the OCI debug-RAM arbiter: FSM states, JTAG
// request kinds, grant owner and jdo field positions.
package hellow_world_cpu_cpu_oci_pkg;

  localparam int JDO_W       = 38;
  localparam int JDO_RDA     = 35;
  localparam int JDO_WD_MSB  = 34;
  localparam int JDO_WD_LSB  = 3;
  localparam int JDO_ADR_LSB = 17;

  typedef enum logic [2:0] {
    IDLE,
    CPU_WR,
    CPU_RD1,
    CPU_RD2,
    J_WR,
    J_RD1,
    J_RD2
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    LOAD_RD,
    WR,
    RD
  } jreq_e;

  typedef enum logic {
    GNT_CPU,
    GNT_JTAG
  } grant_e;

  typedef struct packed {
    jreq_e       typ;
    logic [31:0] wdata;
  } jslot_t;

endpackage

// File: rtl/hellow_world_cpu_cpu_ocimem_jtag_req.sv
// JTAG side: jdo decode, one-deep pending slot, auto-increment address
// pointer, sticky overflow flag and monitor_ready.
// Ports: ocimem strobes + jdo in; done_i from the FSM when a JTAG access
// retires; req_o/type_o/wdata_o/addr_o to the FSM; ovf_o, ready_o out.
module hellow_world_cpu_cpu_ocimem_jtag_req
  import hellow_world_cpu_cpu_oci_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              done_i,
  output logic              req_o,
  output jreq_e             type_o,
  output logic [31:0]       wdata_o,
  output logic [AW-1:0]     addr_o,
  output logic              ovf_o,
  output logic              ready_o
);

  jslot_t        slot_q, slot_d;
  logic          vld_q, vld_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          ovf_q, ovf_d;
  logic          ld_q, ld_d;
  logic          rdy_q, rdy_d;

  logic          strobe;
  logic          accept;
  logic          pend_new;
  jreq_e         s_type;
  logic [31:0]   s_wdata;
  logic          unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  assign strobe  = take_action_ocimem_a
                 | take_action_ocimem_b
                 | take_no_action_ocimem_a;
  assign s_wdata = jdo[JDO_WD_MSB:JDO_WD_LSB];

  always_comb begin
    s_type = NONE;
    unique case (1'b1)
      take_action_ocimem_a:
        s_type = jdo[JDO_RDA] ? LOAD_RD : NONE;
      take_action_ocimem_b:    s_type = WR;
      take_no_action_ocimem_a: s_type = RD;
      default:                 s_type = NONE;
    endcase
  end

  // The slot counts as free in the cycle its access retires.
  assign accept   = strobe & (~vld_q | done_i);
  assign pend_new = accept & (s_type != NONE);

  // A fresh strobe is visible to the arbiter in its own cycle.
  assign req_o   = vld_q | pend_new;
  assign type_o  = vld_q ? slot_q.typ : s_type;
  assign wdata_o = vld_q ? slot_q.wdata : s_wdata;
  assign addr_o  = addr_q;
  assign ovf_o   = ovf_q;
  assign ready_o = rdy_q;

  always_comb begin
    vld_d  = vld_q;
    slot_d = slot_q;
    addr_d = addr_q;
    ovf_d  = ovf_q | (strobe & ~accept);
    ld_d   = accept & take_action_ocimem_a
           & ~jdo[JDO_RDA];
    rdy_d  = rdy_q;
    if (done_i) begin
      vld_d  = 1'b0;
      addr_d = addr_q + 1'b1;
    end
    if (pend_new) begin
      vld_d        = 1'b1;
      slot_d.typ   = s_type;
      slot_d.wdata = s_wdata;
    end
    if (accept && take_action_ocimem_a)
      addr_d = jdo[AW+16:JDO_ADR_LSB];
    if (done_i || ld_q)
      rdy_d = 1'b1;
    if (accept)
      rdy_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= 1'b0;
      slot_q <= '{typ: NONE, wdata: '0};
      addr_q <= '0;
      ovf_q  <= 1'b0;
      ld_q   <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      slot_q <= slot_d;
      addr_q <= addr_d;
      ovf_q  <= ovf_d;
      ld_q   <= ld_d;
      rdy_q  <= rdy_d;
    end
  end

endmodule

// File: rtl/hellow_world_cpu_cpu_ocimem_arb.sv
// Debug-RAM arbiter/sequencer between the JTAG ocimem path and the CPU
// debug_mem_slave port. Ports: JTAG strobes/jdo, CPU Avalon-MM slave,
// RAM master (sync read), MonDReg/monitor_ready/jtag_ovf to JTAG.
// Build option: HELLOW_WORLD_OCIMEM_WRPROT_EN gates non-debug CPU access.
module hellow_world_cpu_cpu_ocimem_arb
  import hellow_world_cpu_cpu_oci_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [JDO_W-1:0]  jdo,
  input  logic [AW-1:0]     cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DW-1:0]     cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  input  logic              cpu_debugaccess,
  output logic              cpu_waitrequest,
  output logic [DW-1:0]     cpu_readdata,
  output logic [AW-1:0]     ram_addr,
  output logic              ram_wr,
  output logic [DW-1:0]     ram_wdata,
  output logic [3:0]        ram_be,
  input  logic [DW-1:0]     ram_rdata,
  output logic [DW-1:0]     MonDReg,
  output logic              monitor_ready,
  output logic              jtag_ovf
);

  state_e        state_q, state_d;
  grant_e        lg_q, lg_d;
  logic [DW-1:0] mon_q, mon_d;
  logic [DW-1:0] crd_q, crd_d;

  logic          cpu_req;
  logic          j_req;
  logic          j_win;
  logic          j_done;
  jreq_e         j_type;
  logic [DW-1:0] j_wdata;
  logic [AW-1:0] jtag_addr;
  logic          cpu_wr_ok;
  logic [DW-1:0] cpu_rd_val;

  hellow_world_cpu_cpu_ocimem_jtag_req #(
    .AW (AW)
  ) u_jreq (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .jdo                     (jdo),
    .done_i                  (j_done),
    .req_o                   (j_req),
    .type_o                  (j_type),
    .wdata_o                 (j_wdata),
    .addr_o                  (jtag_addr),
    .ovf_o                   (jtag_ovf),
    .ready_o                 (monitor_ready)
  );

`ifdef HELLOW_WORLD_OCIMEM_WRPROT_EN
  assign cpu_wr_ok  = cpu_debugaccess;
  assign cpu_rd_val = cpu_debugaccess
                    ? ram_rdata : '0;
`else
  logic unused_dbg;
  assign unused_dbg = cpu_debugaccess;
  assign cpu_wr_ok  = 1'b1;
  assign cpu_rd_val = ram_rdata;
`endif

  assign cpu_req = cpu_read | cpu_write;

  // Contention goes to whoever was not served last.
  assign j_win = j_req
               & (~cpu_req | (lg_q == GNT_CPU));

  assign j_done = (state_q == J_WR)
                | (state_q == J_RD2);

  always_comb begin
    state_d = state_q;
    lg_d    = lg_q;
    unique case (state_q)
      IDLE: begin
        if (j_win) begin
          lg_d    = GNT_JTAG;
          state_d = (j_type == WR) ? J_WR : J_RD1;
        end else if (cpu_req) begin
          lg_d    = GNT_CPU;
          state_d = cpu_write ? CPU_WR : CPU_RD1;
        end
      end
      CPU_WR:  state_d = IDLE;
      CPU_RD1: state_d = CPU_RD2;
      CPU_RD2: state_d = IDLE;
      J_WR:    state_d = IDLE;
      J_RD1:   state_d = J_RD2;
      J_RD2:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_addr  = '0;
    ram_wr    = 1'b0;
    ram_wdata = '0;
    ram_be    = 4'h0;
    unique case (state_q)
      CPU_WR: begin
        ram_addr  = cpu_address;
        ram_wr    = cpu_wr_ok;
        ram_wdata = cpu_writedata;
        ram_be    = cpu_byteenable;
      end
      CPU_RD1, CPU_RD2: begin
        ram_addr = cpu_address;
      end
      J_WR: begin
        ram_addr  = jtag_addr;
        ram_wr    = 1'b1;
        ram_wdata = j_wdata;
        ram_be    = 4'hF;
      end
      J_RD1, J_RD2: begin
        ram_addr = jtag_addr;
      end
      default: begin
        ram_addr = '0;
      end
    endcase
  end

  assign cpu_waitrequest = ~((state_q == CPU_WR)
                           | (state_q == CPU_RD2));

  // Read data is live while waitrequest is low, then held.
  assign cpu_readdata = (state_q == CPU_RD2)
                      ? cpu_rd_val : crd_q;

  assign MonDReg = mon_q;

  always_comb begin
    mon_d = (state_q == J_RD2) ? ram_rdata : mon_q;
    crd_d = (state_q == CPU_RD2) ? cpu_rd_val : crd_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      lg_q    <= GNT_CPU;
      mon_q   <= '0;
      crd_q   <= '0;
    end else begin
      state_q <= state_d;
      lg_q    <= lg_d;
      mon_q   <= mon_d;
      crd_q   <= crd_d;
    end
  end

endmodule

// File: tb/tb_hellow_world_cpu_cpu_ocimem_arb.sv
// Directed bench for the OCI debug-RAM arbiter with a behavioural
// sync-read RAM; prints one summary line.
module tb_hellow_world_cpu_cpu_ocimem_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ta_a, ta_b, tna_a;
  logic [37:0] jdo;
  logic [7:0]  cpu_address;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_writedata;
  logic [3:0]  cpu_byteenable;
  logic        cpu_debugaccess;
  logic        cpu_waitrequest;
  logic [31:0] cpu_readdata;
  logic [7:0]  ram_addr;
  logic        ram_wr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_be;
  logic [31:0] ram_rdata;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        jtag_ovf;

  logic [31:0] mem [256];
  logic        pk_we;
  logic [7:0]  pk_a;
  logic [31:0] pk_d;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hellow_world_cpu_cpu_ocimem_arb dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .take_action_ocimem_a    (ta_a),
    .take_action_ocimem_b    (ta_b),
    .take_no_action_ocimem_a (tna_a),
    .jdo                     (jdo),
    .cpu_address             (cpu_address),
    .cpu_read                (cpu_read),
    .cpu_write               (cpu_write),
    .cpu_writedata           (cpu_writedata),
    .cpu_byteenable          (cpu_byteenable),
    .cpu_debugaccess         (cpu_debugaccess),
    .cpu_waitrequest         (cpu_waitrequest),
    .cpu_readdata            (cpu_readdata),
    .ram_addr                (ram_addr),
    .ram_wr                  (ram_wr),
    .ram_wdata               (ram_wdata),
    .ram_be                  (ram_be),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .jtag_ovf                (jtag_ovf)
  );

  always @(posedge clk) begin
    if (pk_we) begin
      mem[pk_a] <= pk_d;
    end else if (ram_wr) begin
      for (int b = 0; b < 4; b++)
        if (ram_be[b])
          mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    pk_we = 1'b1;
    pk_a  = a;
    pk_d  = d;
    step(1);
    pk_we = 1'b0;
  endtask

  function automatic logic [37:0] jdo_ld(input logic rd,
                                         input logic [7:0] a);
    logic [37:0] j;
    j = '0;
    j[35] = rd;
    j[24:17] = a;
    return j;
  endfunction

  function automatic logic [37:0] jdo_wr(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic test_reset;
    checks++;
    if (cpu_waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait: got %b want 1", cpu_waitrequest);
    end
    checks++;
    if (MonDReg !== 32'h0) begin
      errors++;
      $display("FAIL rst_mon: got %h want 0", MonDReg);
    end
    checks++;
    if (monitor_ready !== 1'b0 || jtag_ovf !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags: got rdy=%b ovf=%b want 0 0",
               monitor_ready, jtag_ovf);
    end
    checks++;
    if (ram_wr !== 1'b0 || ram_addr !== 8'h00) begin
      errors++;
      $display("FAIL rst_ram: got wr=%b addr=%h want 0 00",
               ram_wr, ram_addr);
    end
    checks++;
    if (dut.jtag_addr !== 8'h00) begin
      errors++;
      $display("FAIL rst_jaddr: got %h want 00", dut.jtag_addr);
    end
  endtask

  task automatic test_addr_read;
    ta_a = 1'b1;
    jdo  = jdo_ld(1'b1, 8'h10);
    step(1);
    ta_a = 1'b0;
    checks++;
    if (ram_addr !== 8'h10 || monitor_ready !== 1'b0) begin
      errors++;
      $display("FAIL ard_rd1: got addr=%h rdy=%b want 10 0",
               ram_addr, monitor_ready);
    end
    step(1);
    checks++;
    if (monitor_ready !== 1'b0) begin
      errors++;
      $display("FAIL ard_early: got rdy=%b want 0", monitor_ready);
    end
    step(1);
    checks++;
    if (MonDReg !== 32'hDEADBEEF || monitor_ready !== 1'b1) begin
      errors++;
      $display("FAIL ard_data: got %h rdy=%b want deadbeef 1",
               MonDReg, monitor_ready);
    end
    checks++;
    if (dut.jtag_addr !== 8'h11) begin
      errors++;
      $display("FAIL ard_inc: got %h want 11", dut.jtag_addr);
    end
  endtask

  task automatic test_wrap_write;
    ta_a = 1'b1;
    jdo  = jdo_ld(1'b0, 8'hFF);
    step(1);
    ta_a = 1'b0;
    checks++;
    if (monitor_ready !== 1'b0 || dut.jtag_addr !== 8'hFF) begin
      errors++;
      $display("FAIL ld_cap: got rdy=%b addr=%h want 0 ff",
               monitor_ready, dut.jtag_addr);
    end
    step(1);
    checks++;
    if (monitor_ready !== 1'b1) begin
      errors++;
      $display("FAIL ld_rdy: got %b want 1", monitor_ready);
    end
    ta_b = 1'b1;
    jdo  = jdo_wr(32'h12345678);
    step(1);
    ta_b = 1'b0;
    checks++;
    if (ram_wr !== 1'b1 || ram_addr !== 8'hFF || ram_be !== 4'hF) begin
      errors++;
      $display("FAIL jwr_bus: got wr=%b addr=%h be=%h want 1 ff f",
               ram_wr, ram_addr, ram_be);
    end
    step(1);
    checks++;
    if (mem[8'hFF] !== 32'h12345678) begin
      errors++;
      $display("FAIL jwr_mem: got %h want 12345678", mem[8'hFF]);
    end
    checks++;
    if (dut.jtag_addr !== 8'h00 || monitor_ready !== 1'b1) begin
      errors++;
      $display("FAIL jwr_wrap: got addr=%h rdy=%b want 00 1",
               dut.jtag_addr, monitor_ready);
    end
    tna_a = 1'b1;
    step(1);
    tna_a = 1'b0;
    step(2);
    checks++;
    if (MonDReg !== 32'h0BADF00D || dut.jtag_addr !== 8'h01) begin
      errors++;
      $display("FAIL jrd_next: got %h addr=%h want 0badf00d 01",
               MonDReg, dut.jtag_addr);
    end
  endtask

  task automatic test_byte_write;
    cpu_write      = 1'b1;
    cpu_address    = 8'h30;
    cpu_byteenable = 4'b0011;
    cpu_writedata  = 32'hAABBCCDD;
    step(1);
    checks++;
    if (cpu_waitrequest !== 1'b0 || ram_wr !== 1'b1) begin
      errors++;
      $display("FAIL cwr_grant: got wait=%b wr=%b want 0 1",
               cpu_waitrequest, ram_wr);
    end
    step(1);
    cpu_write = 1'b0;
    checks++;
    if (cpu_waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL cwr_1cyc: got wait=%b want 1", cpu_waitrequest);
    end
    checks++;
    if (mem[8'h30] !== 32'h0000CCDD) begin
      errors++;
      $display("FAIL cwr_mem: got %h want 0000ccdd", mem[8'h30]);
    end
  endtask

  task automatic test_simultaneous;
    int lows;
    lows = 0;
    cpu_read    = 1'b1;
    cpu_address = 8'h20;
    tna_a       = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step(1);
      tna_a = 1'b0;
      if (cpu_waitrequest === 1'b0) lows++;
      checks++;
      if (cpu_waitrequest !== ((k == 4) ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL sim_wait%0d: got %b want %b", k,
                 cpu_waitrequest, (k == 4) ? 1'b0 : 1'b1);
      end
      if (k == 2) begin
        checks++;
        if (MonDReg !== 32'h11110001 || monitor_ready !== 1'b1) begin
          errors++;
          $display("FAIL sim_jtag: got %h rdy=%b want 11110001 1",
                   MonDReg, monitor_ready);
        end
      end
      if (k == 4) begin
        checks++;
        if (cpu_readdata !== 32'hCAFE0020) begin
          errors++;
          $display("FAIL sim_cpu: got %h want cafe0020", cpu_readdata);
        end
        cpu_read = 1'b0;
      end
    end
    checks++;
    if (lows != 1) begin
      errors++;
      $display("FAIL sim_once: got %0d low cycles want 1", lows);
    end
  endtask

  task automatic test_overflow;
    cpu_read    = 1'b1;
    cpu_address = 8'h40;
    step(1);
    tna_a = 1'b1;
    step(1);
    checks++;
    if (cpu_waitrequest !== 1'b0 || cpu_readdata !== 32'h40404040) begin
      errors++;
      $display("FAIL ovf_cpu: got wait=%b %h want 0 40404040",
               cpu_waitrequest, cpu_readdata);
    end
    cpu_read = 1'b0;
    step(1);
    tna_a = 1'b0;
    checks++;
    if (jtag_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got %b want 1", jtag_ovf);
    end
    step(3);
    checks++;
    if (MonDReg !== 32'h22220002 || monitor_ready !== 1'b1) begin
      errors++;
      $display("FAIL ovf_first: got %h rdy=%b want 22220002 1",
               MonDReg, monitor_ready);
    end
    checks++;
    if (dut.jtag_addr !== 8'h03) begin
      errors++;
      $display("FAIL ovf_drop: got addr=%h want 03", dut.jtag_addr);
    end
    step(2);
    checks++;
    if (jtag_ovf !== 1'b1 || monitor_ready !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got ovf=%b rdy=%b want 1 1",
               jtag_ovf, monitor_ready);
    end
  endtask

  task automatic test_reset_mid;
    tna_a = 1'b1;
    step(1);
    tna_a = 1'b0;
    checks++;
    if (ram_addr !== 8'h03) begin
      errors++;
      $display("FAIL rmid_rd1: got addr=%h want 03", ram_addr);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (MonDReg !== 32'h0 || jtag_ovf !== 1'b0
        || monitor_ready !== 1'b0) begin
      errors++;
      $display("FAIL rmid_async: got %h ovf=%b rdy=%b want 0 0 0",
               MonDReg, jtag_ovf, monitor_ready);
    end
    checks++;
    if (ram_addr !== 8'h00 || cpu_waitrequest !== 1'b1
        || ram_wr !== 1'b0) begin
      errors++;
      $display("FAIL rmid_bus: got addr=%h wait=%b wr=%b want 00 1 0",
               ram_addr, cpu_waitrequest, ram_wr);
    end
    step(1);
    reset_n = 1'b1;
    step(4);
    checks++;
    if (monitor_ready !== 1'b0 || ram_addr !== 8'h00
        || MonDReg !== 32'h0) begin
      errors++;
      $display("FAIL rmid_after: got rdy=%b addr=%h %h want 0 00 0",
               monitor_ready, ram_addr, MonDReg);
    end
    checks++;
    if (dut.jtag_addr !== 8'h00) begin
      errors++;
      $display("FAIL rmid_jaddr: got %h want 00", dut.jtag_addr);
    end
  endtask

  initial begin
    reset_n         = 1'b0;
    ta_a            = 1'b0;
    ta_b            = 1'b0;
    tna_a           = 1'b0;
    jdo             = '0;
    cpu_address     = '0;
    cpu_read        = 1'b0;
    cpu_write       = 1'b0;
    cpu_writedata   = '0;
    cpu_byteenable  = 4'h0;
    cpu_debugaccess = 1'b1;
    pk_we           = 1'b0;
    pk_a            = '0;
    pk_d            = '0;
    step(1);
    poke(8'h10, 32'hDEADBEEF);
    poke(8'h00, 32'h0BADF00D);
    poke(8'h01, 32'h11110001);
    poke(8'h02, 32'h22220002);
    poke(8'h03, 32'h33330003);
    poke(8'h20, 32'hCAFE0020);
    poke(8'h30, 32'h00000000);
    poke(8'h40, 32'h40404040);
    poke(8'hFF, 32'h00000000);
    test_reset;
    reset_n = 1'b1;
    step(2);
    test_addr_read;
    test_wrap_write;
    test_byte_write;
    test_simultaneous;
    test_overflow;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
